shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; power of two, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 SHALL derive localparam SHAMT_W = log2(WIDTH), which is also the number of pipeline stages.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted this cycle when in_valid & in_ready.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_shamt  input  SHAMT_W  shift/rotate amount.
REQ-010 in_op  input  3  operation, shift_op_e from the shared package.
REQ-011 in_tag  input  TAG_W  opaque tag, returned unmodified.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-014 out_data  output  WIDTH  result.
REQ-015 out_tag  output  TAG_W  tag of the request that produced out_data.

Function
REQ-016 Op encoding SHALL be: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; 010, 110 and 111 are reserved and SHALL pass in_data through unshifted.
REQ-017 SLL/SRL SHALL zero-fill; SRA SHALL fill with operand bit WIDTH-1; ROL/ROR SHALL wrap vacated bits from the opposite end, with the amount taken modulo WIDTH.
REQ-018 Left operations SHALL be implemented by bit-reversal before and after a right-shift datapath; the fill bit SHALL be the sign only for SRA.
REQ-019 Stage k (k = 0..SHAMT_W-1) SHALL conditionally shift by 2^k when shamt bit k is set, then register data, remaining control, tag and a valid bit.
REQ-020 Latency SHALL be exactly SHAMT_W cycles from acceptance to out_valid when out_ready is held high (5 cycles for WIDTH=32).
REQ-021 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-022 Pipeline advance SHALL be advance = ~out_valid | out_ready; all stages SHALL hold when advance=0.
REQ-023 in_ready SHALL equal advance and SHALL NOT depend on in_valid.
REQ-024 Bubbles SHALL propagate as invalid stages; they are not collapsed.
REQ-025 out_data and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Requests SHALL be delivered in acceptance order, with none lost or duplicated.
REQ-027 shamt=0 SHALL return the operand unchanged for every op.
REQ-028 Simultaneous accept and output consume in one cycle SHALL both take effect.

Reset
REQ-029 While rst_n=0, all stage valid bits, data, control and tag registers SHALL be 0; out_valid=0, out_data=0, out_tag=0.
REQ-030 Assertion of rst_n mid-operation SHALL discard all in-flight operations immediately, without waiting for a clock edge.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package shift_pkg SHALL hold the shift_op_e enum and the helper function bit_reverse.
REQ-033 One sub-module, shift_stage, SHALL implement a single shift-by-2^k step plus its pipeline register, parametrised by WIDTH, TAG_W and stage index; shift_pipe SHALL instantiate SHAMT_W of them in a generate loop.

Verification (WIDTH=32)
REQ-034 SRA 0x80000000, shamt 4, tag 3 -> after 5 cycles out_data 0xF8000000, out_tag 3.
REQ-035 ROL 0x80000001, shamt 1, followed back-to-back by ROR 0x00000001, shamt 31 -> consecutive outputs 0x00000003 then 0x00000002.
REQ-036 10 back-to-back SLL 0x1 with shamt 0..9 while out_ready is held low after the first result -> in_ready=0 once the pipe fills, head output stable at 0x00000001; after release, outputs 0x1,0x2,...,0x200 in order.
REQ-037 rst_n pulsed low between clock edges with 3 operations in flight -> out_valid=0 immediately, no stale output afterwards, in_ready=1.
REQ-038 Reserved op 111 with 0xDEADBEEF, shamt 7 -> out_data 0xDEADBEEF; SRL 0xFFFFFFFF, shamt 31 -> 0x00000001.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding,
// per-stage control bit positions and the bit reversal used by left operations.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b011,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_e;

    // Control word carried down the pipe alongside each operation.
    localparam int CTRL_W    = 3;
    localparam int CTRL_ROT  = 0;
    localparam int CTRL_FILL = 1;
    localparam int CTRL_REV  = 2;

    localparam int MAX_WIDTH = 64;

    // Reverses all MAX_WIDTH bits; a WIDTH-bit operand zero-extended into v
    // comes back reversed in the top WIDTH bits of the result.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v);
        logic [MAX_WIDTH-1:0] r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = v[MAX_WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One right-shift-by-2^STAGE step followed by its pipeline register; the step
// is applied only when shamt bit STAGE is set, and everything holds when advance=0.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int STAGE = 0,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int SHIFT = 1 << STAGE;

    logic [WIDTH-1:0]   shifted;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic [SHAMT_W-1:0] shamt_d, shamt_q;
    logic [CTRL_W-1:0]  ctrl_d, ctrl_q;
    logic [TAG_W-1:0]   tag_d, tag_q;

    always_comb begin
        shifted = in_data;
        if (in_shamt[STAGE]) begin
            if (in_ctrl[CTRL_ROT]) begin
                shifted = {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
            end else begin
                shifted = {{SHIFT{in_ctrl[CTRL_FILL]}}, in_data[WIDTH-1:SHIFT]};
            end
        end
    end

    // Bubbles are loaded like any other slot so they keep their position.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        ctrl_d  = ctrl_q;
        tag_d   = tag_q;
        if (advance) begin
            valid_d = in_valid;
            data_d  = shifted;
            shamt_d = in_shamt;
            ctrl_d  = in_ctrl;
            tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            ctrl_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            ctrl_q  <= ctrl_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_ctrl  = ctrl_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter/rotator: one stage per shamt bit over a right-shift datapath,
// with left operations handled by reversing the operand on entry and the result on exit.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    // Handshake: a request transfers on a rising edge when in_valid & in_ready,
    // a result transfers when out_valid & out_ready; both may happen on one edge.
    logic advance;

    logic                 valid_l [0:SHAMT_W];
    logic [WIDTH-1:0]     data_l  [0:SHAMT_W];
    logic [SHAMT_W-1:0]   shamt_l [0:SHAMT_W];
    logic [CTRL_W-1:0]    ctrl_l  [0:SHAMT_W];
    logic [TAG_W-1:0]     tag_l   [0:SHAMT_W];

    logic [WIDTH-1:0]     s0_data;
    logic [SHAMT_W-1:0]   s0_shamt;
    logic [CTRL_W-1:0]    s0_ctrl;
    logic [MAX_WIDTH-1:0] in_rev;
    logic [MAX_WIDTH-1:0] out_rev;
    shift_op_e            op;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    always_comb begin
        op       = shift_op_e'(in_op);
        in_rev   = bit_reverse(MAX_WIDTH'(in_data));
        s0_data  = in_data;
        s0_shamt = in_shamt;
        s0_ctrl  = '0;
        case (op)
            OP_SLL: s0_ctrl[CTRL_REV] = 1'b1;
            OP_SRL: s0_ctrl = '0;
            OP_SRA: s0_ctrl[CTRL_FILL] = in_data[WIDTH-1];
            OP_ROL: begin
                s0_ctrl[CTRL_REV] = 1'b1;
                s0_ctrl[CTRL_ROT] = 1'b1;
            end
            OP_ROR: s0_ctrl[CTRL_ROT] = 1'b1;
            // Reserved encodings travel unshifted.
            default: s0_shamt = '0;
        endcase
        if (s0_ctrl[CTRL_REV]) begin
            s0_data = in_rev[MAX_WIDTH-1 -: WIDTH];
        end
    end

    assign valid_l[0] = in_valid;
    assign data_l[0]  = s0_data;
    assign shamt_l[0] = s0_shamt;
    assign ctrl_l[0]  = s0_ctrl;
    assign tag_l[0]   = in_tag;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .STAGE (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance),
            .in_valid  (valid_l[k]),
            .in_data   (data_l[k]),
            .in_shamt  (shamt_l[k]),
            .in_ctrl   (ctrl_l[k]),
            .in_tag    (tag_l[k]),
            .out_valid (valid_l[k+1]),
            .out_data  (data_l[k+1]),
            .out_shamt (shamt_l[k+1]),
            .out_ctrl  (ctrl_l[k+1]),
            .out_tag   (tag_l[k+1])
        );
    end

    // The exit reversal is combinational off the last register, so the result
    // stays stable while stalled and is zero while in reset.
    always_comb begin
        out_rev  = bit_reverse(MAX_WIDTH'(data_l[SHAMT_W]));
        out_data = data_l[SHAMT_W];
        if (ctrl_l[SHAMT_W][CTRL_REV]) begin
            out_data = out_rev[MAX_WIDTH-1 -: WIDTH];
        end
    end

    assign out_valid = valid_l[SHAMT_W];
    assign out_tag   = tag_l[SHAMT_W];

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe (WIDTH=32): latency, op results, back-to-back,
// backpressure stall and asynchronous reset with operations in flight.
module tb_shift_pipe;

    localparam int WIDTH   = 32;
    localparam int TAG_W   = 4;
    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data = '0;
    logic [SHAMT_W-1:0] in_shamt = '0;
    logic [2:0]         in_op = '0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit sender_done = 1'b0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] got_data_q[$];
    logic [TAG_W-1:0] got_tag_q[$];
    int               got_cyc_q[$];

    shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // Results consumed on the coming edge are recorded mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_data_q.push_back(out_data);
            got_tag_q.push_back(out_tag);
            got_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_q();
        exp_q.delete();
        got_data_q.delete();
        got_tag_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = op;
        in_tag   = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_accept: tag %0d in_ready=%b, required 1 within 200 cycles", tag, in_ready);
        end
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 300; i++) begin
            if (got_data_q.size() >= n) break;
            @(negedge clk);
        end
        checks++;
        if (got_data_q.size() < n) begin
            errors++;
            $display("FAIL wait_results: got %0d results, required %0d", got_data_q.size(), n);
            while (got_data_q.size() < n) begin
                got_data_q.push_back('x);
                got_tag_q.push_back('x);
                got_cyc_q.push_back(0);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h, required 00000000", out_data); end
        checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h, required 0", out_tag); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_sra_latency();
        int lat = 0;
        clear_q();
        out_ready = 1'b1;
        send(32'h8000_0000, 5'd4, 3'b011, 4'd3);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat != 5) begin errors++; $display("FAIL sra_latency: got %0d cycles, required 5", lat); end
        checks++; if (out_data !== 32'hF800_0000) begin errors++; $display("FAIL sra_data: got %h, required f8000000", out_data); end
        checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL sra_tag: got %0d, required 3", out_tag); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_rotate();
        clear_q();
        out_ready = 1'b1;
        send(32'h8000_0001, 5'd1, 3'b100, 4'd5);
        send(32'h0000_0001, 5'd31, 3'b101, 4'd6);
        in_valid = 1'b0;
        wait_results(2);
        checks++; if (got_data_q[0] !== 32'h0000_0003) begin errors++; $display("FAIL rol_data: got %h, required 00000003", got_data_q[0]); end
        checks++; if (got_data_q[1] !== 32'h0000_0002) begin errors++; $display("FAIL ror_data: got %h, required 00000002", got_data_q[1]); end
        checks++; if (got_tag_q[1] !== 4'd6) begin errors++; $display("FAIL ror_tag: got %0d, required 6", got_tag_q[1]); end
        checks++; if (got_cyc_q[1] - got_cyc_q[0] != 1) begin errors++; $display("FAIL rotate_consecutive: gap %0d cycles, required 1", got_cyc_q[1] - got_cyc_q[0]); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_op_table();
        logic [WIDTH-1:0]   t_data [13] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                                            32'h8000_0F01, 32'h8000_0F01, 32'h8000_0F01, 32'h0000_0001,
                                            32'h7FFF_FFFF, 32'hF000_0000, 32'h1234_5678, 32'h1234_5678,
                                            32'h8000_0000};
        logic [SHAMT_W-1:0] t_shamt [13] = '{5'd7, 5'd31, 5'd5, 5'd31, 5'd0, 5'd0, 5'd0, 5'd31,
                                             5'd31, 5'd8, 5'd8, 5'd4, 5'd16};
        logic [2:0]         t_op [13] = '{3'b111, 3'b001, 3'b010, 3'b110, 3'b000, 3'b011, 3'b100,
                                          3'b000, 3'b011, 3'b011, 3'b100, 3'b101, 3'b001};
        logic [WIDTH-1:0]   t_exp [13] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h1234_5678, 32'h1234_5678,
                                           32'h8000_0F01, 32'h8000_0F01, 32'h8000_0F01, 32'h8000_0000,
                                           32'h0000_0000, 32'hFFF0_0000, 32'h3456_7812, 32'h8123_4567,
                                           32'h0000_8000};
        logic [WIDTH-1:0]   e;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send(t_data[i], t_shamt[i], t_op[i], TAG_W'(i));
            exp_q.push_back(t_exp[i]);
        end
        in_valid = 1'b0;
        wait_results(13);
        for (int i = 0; i < 13; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_data_q[i] !== e) begin
                errors++;
                $display("FAIL op_table_data[%0d]: op %b shamt %0d got %h, required %h", i, t_op[i], t_shamt[i], got_data_q[i], e);
            end
            checks++;
            if (got_tag_q[i] !== TAG_W'(i)) begin
                errors++;
                $display("FAIL op_table_tag[%0d]: got %0d, required %0d", i, got_tag_q[i], i);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic stall_sender();
        for (int i = 0; i < 10; i++) begin
            send(32'h0000_0001, SHAMT_W'(i), 3'b000, TAG_W'(i));
        end
        in_valid = 1'b0;
        sender_done = 1'b1;
    endtask

    task automatic test_stall();
        clear_q();
        out_ready = 1'b0;
        sender_done = 1'b0;
        fork
            stall_sender();
        join_none
        repeat (12) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b, required 1", out_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_data !== 32'h0000_0001 || out_tag !== 4'd0) begin
                errors++;
                $display("FAIL stall_head_stable: got %h tag %0d, required 00000001 tag 0", out_data, out_tag);
            end
        end
        checks++; if (got_data_q.size() != 0) begin errors++; $display("FAIL stall_no_consume: got %0d results, required 0", got_data_q.size()); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_results(10);
        for (int i = 0; i < 300 && !sender_done; i++) @(negedge clk);
        checks++; if (!sender_done) begin errors++; $display("FAIL stall_sender_done: got 0, required 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_data_q[i] !== (32'h1 << i) || got_tag_q[i] !== TAG_W'(i)) begin
                errors++;
                $display("FAIL stall_order[%0d]: got %h tag %0d, required %h tag %0d", i, got_data_q[i], got_tag_q[i], 32'h1 << i, i);
            end
        end
        checks++; if (got_data_q.size() != 10) begin errors++; $display("FAIL stall_count: got %0d results, required 10", got_data_q.size()); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_flight();
        bit seen = 1'b0;
        clear_q();
        out_ready = 1'b1;
        send(32'h0000_0001, 5'd1, 3'b000, 4'd1);
        send(32'h0000_0001, 5'd2, 3'b000, 4'd2);
        send(32'h0000_0001, 5'd3, 3'b000, 4'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL flight_out_valid: got 0, required 1 before reset"); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b, required 0", out_valid); end
        checks++; if (out_data !== 32'h0 || out_tag !== 4'h0) begin errors++; $display("FAIL async_reset_data: got %h tag %0d, required 0", out_data, out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        clear_q();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
        repeat (10) @(negedge clk);
        checks++; if (got_data_q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_stale: got %0d results valid=%b, required 0", got_data_q.size(), out_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sra_latency();
        test_back_to_back_rotate();
        test_op_table();
        test_stall();
        test_reset_in_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
